// File: rtl/fas_frame_sched_if.sv
// fas_frame_sched_if: FIR-sample / FFT start-done bundle between the filter, the scheduler and the FFT core.
`default_nettype none

interface fas_frame_sched_if #(
  parameter int N      = 16,
  parameter int DW     = 16,
  parameter int FRAMES = 64
);
  logic                      fir_valid;
  logic [DW-1:0]             fir_d;
  logic                      fft_ready;
  logic                      fft_done;
  logic                      fft_start;
  logic                      fft_bank;
  logic [N*DW-1:0]           fft_frame;
  logic [$clog2(FRAMES)-1:0] frame_idx;
  logic                      all_done;
  logic                      ovf;
  logic [7:0]                drop_cnt;

  modport master (
    output fir_valid, fir_d, fft_ready, fft_done,
    input  fft_start, fft_bank, fft_frame, frame_idx, all_done, ovf, drop_cnt
  );

  modport slave (
    input  fir_valid, fir_d, fft_ready, fft_done,
    output fft_start, fft_bank, fft_frame, frame_idx, all_done, ovf, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/fas_frame_sched.sv
// fas_frame_sched: ping-pong 16-sample frame collector feeding the FFT with a start/done handshake.
// FAS_SCHED_OVF_EN: when defined, keeps the sticky ovf flag and saturating drop counter.
`default_nettype none

module fas_frame_sched #(
  parameter int N      = 16,
  parameter int DW     = 16,
  parameter int FRAMES = 64
) (
  input  logic clk,
  input  logic rst,
  fas_frame_sched_if.slave bus
);
  localparam int CW = $clog2(N);
  localparam int IW = $clog2(FRAMES);
  localparam int FW = $clog2(FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [N*DW-1:0] bank [2];
  logic [1:0]      full;
  logic            wr_bank;
  logic            rd_bank;
  logic            inflight;
  logic [CW-1:0]   wr_cnt;
  logic [FW-1:0]   fill_cnt;
  logic [IW-1:0]   frame_idx;
  logic            fft_start;
  logic            fft_bank;
  logic            all_done;

  logic accepting;
  logic wr_en;
  logic last_wr;
  logic complete;
  logic launch;

  always_comb begin
    accepting = (state == IDLE) || (state == RUN);
    wr_en     = bus.fir_valid && accepting && !full[wr_bank];
    last_wr   = wr_en && (wr_cnt == CW'(N - 1));
    complete  = bus.fft_done && inflight;
    launch    = full[rd_bank] && !inflight && bus.fft_ready && (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bank[0]   <= '0;
      bank[1]   <= '0;
      full      <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      inflight  <= 1'b0;
      wr_cnt    <= '0;
      fill_cnt  <= '0;
      frame_idx <= '0;
      fft_start <= 1'b0;
      fft_bank  <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      fft_start <= launch;
      if (launch) begin
        inflight <= 1'b1;
        fft_bank <= rd_bank;
      end

      if (wr_en) begin
        bank[wr_bank][wr_cnt*DW +: DW] <= bus.fir_d;
        if (last_wr) begin
          full[wr_bank] <= 1'b1;
          wr_cnt        <= '0;
          wr_bank       <= ~wr_bank;
          fill_cnt      <= fill_cnt + 1'b1;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      // Launch needs !inflight and completion needs inflight, so they never collide.
      if (complete) begin
        full[rd_bank] <= 1'b0;
        inflight      <= 1'b0;
        rd_bank       <= ~rd_bank;
        frame_idx     <= (frame_idx == IW'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;
      end

      case (state)
        IDLE:    if (bus.fir_valid) state <= RUN;
        RUN:     if (last_wr && (fill_cnt == FW'(FRAMES - 1))) state <= DRAIN;
        DRAIN: begin
          if (complete && (frame_idx == IW'(FRAMES - 1))) begin
            state    <= DONE;
            all_done <= 1'b1;
          end
        end
        default: state <= DONE;
      endcase
    end
  end

  assign bus.fft_start = fft_start;
  assign bus.fft_bank  = fft_bank;
  assign bus.fft_frame = bank[rd_bank];
  assign bus.frame_idx = frame_idx;
  assign bus.all_done  = all_done;

`ifdef FAS_SCHED_OVF_EN
  logic       drop;
  logic       ovf;
  logic [7:0] drop_cnt;

  assign drop = bus.fir_valid && accepting && full[wr_bank];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.ovf      = ovf;
  assign bus.drop_cnt = drop_cnt;
`else
  assign bus.ovf      = 1'b0;
  assign bus.drop_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fas_frame_sched.sv
// tb_fas_frame_sched: directed vectors for fas_frame_sched with a small FFT-core responder.
`default_nettype none

module tb_fas_frame_sched;
`ifdef FAS_SCHED_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  fas_frame_sched_if #(.N(16), .DW(16), .FRAMES(64)) fsif ();

  fas_frame_sched #(.N(16), .DW(16), .FRAMES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (fsif)
  );

  always #5 clk = ~clk;

  int   vec_cnt = 0;
  int   err_cnt = 0;
  bit   fft_auto = 1'b1;
  int   fft_lat = 5;
  int   cd = 0;
  int   start_cnt = 0;
  bit   bank_log [$];
  time  last_done_t = 0;
  int   alt_err;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FFT core model: logs every start and, in auto mode, answers with fft_done after fft_lat cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        cd = 0;
        if (fft_auto) fsif.fft_done = 1'b0;
      end else begin
        if (fft_auto) begin
          fsif.fft_done = 1'b0;
          if (cd > 0) begin
            cd--;
            if (cd == 0) fsif.fft_done = 1'b1;
          end
        end
        if (fsif.fft_start) begin
          start_cnt++;
          bank_log.push_back(fsif.fft_bank);
          if (fft_auto) cd = fft_lat;
        end
      end
    end
  end

  always @(posedge clk) if (fsif.fft_done) last_done_t = $time;

  task automatic do_reset();
    rst = 1'b1;
    fsif.fir_valid = 1'b0;
    fsif.fir_d = '0;
    fsif.fft_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start_cnt = 0;
    bank_log.delete();
    rst = 1'b0;
  endtask

  task automatic send(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fsif.fir_valid = 1'b1;
      fsif.fir_d = base + 16'(i);
    end
    @(negedge clk);
    fsif.fir_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    fsif.fft_ready = 1'b1;
    do_reset();

    // Reset values
    check("rst_start", fsif.fft_start, 0);
    check("rst_bank", fsif.fft_bank, 0);
    check("rst_frame", fsif.fft_frame, 0);
    check("rst_idx", fsif.frame_idx, 0);
    check("rst_all_done", fsif.all_done, 0);
    check("rst_ovf", fsif.ovf, 0);
    check("rst_drop", fsif.drop_cnt, 0);

    // Single frame 0x0001..0x0010
    fft_auto = 1'b1;
    fft_lat = 5;
    send(16, 16'h0001);
    check("t1_no_early_start", fsif.fft_start, 0);
    @(negedge clk);
    check("t1_start", fsif.fft_start, 1);
    check("t1_bank", fsif.fft_bank, 0);
    check("t1_s0", fsif.fft_frame[15:0], 16'h0001);
    check("t1_s15", fsif.fft_frame[255:240], 16'h0010);
    @(negedge clk);
    check("t1_start_pulse", fsif.fft_start, 0);
    for (int i = 0; i < 20 && fsif.frame_idx != 6'd1; i++) @(negedge clk);
    check("t1_idx", fsif.frame_idx, 1);
    check("t1_start_cnt", start_cnt, 1);

    // Full 1024-sample stream, FFT latency 8
    do_reset();
    fft_lat = 8;
    send(1024, 16'h0001);
    for (int i = 0; i < 100 && !fsif.all_done; i++) @(negedge clk);
    check("t2_all_done", fsif.all_done, 1);
    check("t2_all_done_lat", 64'($time - last_done_t), 5);
    check("t2_starts", start_cnt, 64);
    alt_err = 0;
    foreach (bank_log[i]) if (bank_log[i] != 1'(i % 2)) alt_err++;
    check("t2_alternate", alt_err, 0);
    check("t2_idx_wrap", fsif.frame_idx, 0);
    check("t2_ovf", fsif.ovf, 0);
    check("t2_drop", fsif.drop_cnt, 0);
    send(16, 16'h0500);
    @(negedge clk);
    check("t2_done_no_start", start_cnt, 64);
    check("t2_done_no_drop", fsif.drop_cnt, 0);
    check("t2_done_hold", fsif.all_done, 1);

    // Overflow: FFT stalled while 40 samples stream
    do_reset();
    fsif.fft_ready = 1'b0;
    send(40, 16'h0001);
    check("t3_drop", fsif.drop_cnt, OVF_ON ? 8 : 0);
    check("t3_ovf", fsif.ovf, OVF_ON ? 1 : 0);
    check("t3_no_start", start_cnt, 0);
    fft_lat = 8;
    fsif.fft_ready = 1'b1;
    for (int i = 0; i < 10 && !fsif.fft_start; i++) @(negedge clk);
    check("t3_start0", fsif.fft_start, 1);
    check("t3_bank0", fsif.fft_bank, 0);
    check("t3_frame0", fsif.fft_frame[15:0], 16'h0001);
    @(negedge clk);
    for (int i = 0; i < 40 && !fsif.fft_start; i++) @(negedge clk);
    check("t3_start1", fsif.fft_start, 1);
    check("t3_bank1", fsif.fft_bank, 1);
    check("t3_frame1", fsif.fft_frame[15:0], 16'h0011);
    check("t3_starts", start_cnt, 2);

    // fft_done frees bank 0 in the same cycle a sample hits it
    fft_auto = 1'b0;
    fsif.fft_ready = 1'b0;
    do_reset();
    send(32, 16'h0001);
    fsif.fft_ready = 1'b1;
    for (int i = 0; i < 5 && !fsif.fft_start; i++) @(negedge clk);
    check("t4_start0", fsif.fft_start, 1);
    fsif.fft_ready = 1'b0;
    fsif.fft_done = 1'b1;
    fsif.fir_valid = 1'b1;
    fsif.fir_d = 16'h00AA;
    @(negedge clk);
    fsif.fft_done = 1'b0;
    fsif.fir_d = 16'h00BB;
    @(negedge clk);
    fsif.fir_valid = 1'b0;
    check("t4_drop", fsif.drop_cnt, OVF_ON ? 1 : 0);
    check("t4_idx", fsif.frame_idx, 1);
    send(15, 16'h0101);
    fsif.fft_ready = 1'b1;
    for (int i = 0; i < 5 && !fsif.fft_start; i++) @(negedge clk);
    check("t4_start1", fsif.fft_start, 1);
    check("t4_bank1", fsif.fft_bank, 1);
    fsif.fft_ready = 1'b0;
    fsif.fft_done = 1'b1;
    @(negedge clk);
    fsif.fft_done = 1'b0;
    check("t4_idx2", fsif.frame_idx, 2);
    check("t4_b0_s0", fsif.fft_frame[15:0], 16'h00BB);
    check("t4_b0_s1", fsif.fft_frame[31:16], 16'h0101);
    check("t4_b0_s15", fsif.fft_frame[255:240], 16'h010F);
    check("t4_drop_final", fsif.drop_cnt, OVF_ON ? 1 : 0);

    // Reset with a frame in flight
    do_reset();
    fft_auto = 1'b1;
    fft_lat = 30;
    fsif.fft_ready = 1'b1;
    send(20, 16'h0001);
    check("t5_inflight_start", start_cnt, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_start", fsif.fft_start, 0);
    check("t5_rst_bank", fsif.fft_bank, 0);
    check("t5_rst_frame", fsif.fft_frame, 0);
    check("t5_rst_idx", fsif.frame_idx, 0);
    check("t5_rst_all_done", fsif.all_done, 0);
    check("t5_rst_ovf", fsif.ovf, 0);
    check("t5_rst_drop", fsif.drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    start_cnt = 0;
    fft_lat = 5;
    send(16, 16'h0100);
    @(negedge clk);
    check("t5_start", fsif.fft_start, 1);
    check("t5_bank", fsif.fft_bank, 0);
    check("t5_s0", fsif.fft_frame[15:0], 16'h0100);
    check("t5_s15", fsif.fft_frame[255:240], 16'h010F);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fas_frame_sched.md
# fas_frame_sched

Ping-pong frame scheduler between the FIR filter and the 16-point FFT core in FAS. Collects FIR output samples into 16-sample frames across two banks and launches the FFT on each full frame with a start/done handshake. Holds the frame stable while the FFT runs, counts completed frames and flags end-of-stream so the frequency-analysis stage can start.

## Interface
- N, 16, samples per frame (FFT size)
- DW, 16, sample width (FIR output, 8.8 signed)
- FRAMES, 64, frames per stream (1024 samples)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- fir_valid  in  1  fir_d holds a sample this cycle
- fir_d  in  DW  FIR output sample
- fft_ready  in  1  FFT core idle, can accept a start
- fft_done  in  1  one-cycle pulse: FFT finished the frame in flight
- fft_start  out  1  one-cycle pulse: frame on fft_frame is valid, begin
- fft_bank  out  1  bank index being presented
- fft_frame  out  N*DW  frame data, sample 0 at bits [DW-1:0]
- frame_idx  out  $clog2(FRAMES)  count of completed frames, wraps at FRAMES
- all_done  out  1  level: FRAMES frames completed
- ovf  out  1  sticky: a sample was dropped
- drop_cnt  out  8  dropped-sample count, saturates at 255

## Operation
- Two banks of N×DW registers, each with a full flag. Write pointer wr_bank and fill count wr_cnt (0..N-1). Read pointer rd_bank. inflight flag.
- States: IDLE → RUN on first fir_valid. RUN → DRAIN once FRAMES×N samples have been accepted. DRAIN → DONE on the fft_done that completes frame FRAMES. DONE holds until rst.
- Write: on fir_valid in IDLE/RUN with full[wr_bank]=0, store at bank[wr_bank][wr_cnt] and increment wr_cnt. On the N-th write: set full[wr_bank], wr_cnt←0, toggle wr_bank.
- Drop: on fir_valid with full[wr_bank]=1, discard the sample, set ovf, increment drop_cnt. Dropped samples do not count toward FRAMES×N.
- In DRAIN/DONE, fir_valid is ignored. It is not counted as a drop.
- Launch: when full[rd_bank]=1, inflight=0 and fft_ready=1, pulse fft_start, set inflight, and drive fft_bank=rd_bank.
- fft_frame always shows bank[rd_bank]. It is stable from fft_start until fft_done because a full bank is never written.
- Complete: fft_done with inflight=1 clears full[rd_bank] and inflight, toggles rd_bank and increments frame_idx. fft_done with inflight=0 is ignored.
- Banks are served strictly in fill order, alternating 0,1,0,1…

## Timing
- Reset values: fft_start=0, fft_bank=0, fft_frame=0, frame_idx=0, all_done=0, ovf=0, drop_cnt=0. wr_bank=rd_bank=0, wr_cnt=0, full=00, inflight=0, state IDLE.
- rst mid-operation discards partial and full frames and any inflight frame. All counters are cleared.
- Latency: N-th sample at edge t sets full at t. fft_start is registered and asserted at t+1 when fft_ready is high.
- Earliest relaunch is the cycle after fft_done, since inflight is cleared at the fft_done edge.
- Same cycle as fft_done freeing bank X, a sample arriving with wr_bank=X full is dropped. The free takes effect next cycle.
- Same cycle, a write and a completion on different banks both take effect.
- all_done rises the cycle after the FRAMES-th fft_done and stays high. frame_idx wraps to 0 at that point.
- fft_start never asserts in DONE.

## Configuration
- FAS_SCHED_OVF_EN
  - Defined: ovf and drop_cnt behave as above.
  - Undefined: ovf and drop_cnt are tied to 0 and the drop counter logic is removed. Sample-dropping behaviour is unchanged.

## Test plan
- Reset, fft_ready=1, 16 consecutive fir_valid samples 0x0001..0x0010, fft_done 5 cycles after start → single fft_start one cycle after the 16th sample, fft_bank=0, fft_frame[15:0]=0x0001, fft_frame[255:240]=0x0010, frame_idx=1 after done.
- 1024 continuous samples, FFT latency 8 cycles → 64 fft_start pulses alternating bank 0/1, ovf=0, all_done=1 the cycle after the 64th fft_done, frame_idx=0.
- fft_ready=0 for 40 cycles while 40 samples stream → banks 0 and 1 full, 8 samples dropped, drop_cnt=8, ovf=1. After release, frames launch in order 0,1.
- fft_done in the same cycle as a sample arriving at full bank 0, both banks full → that sample dropped (drop_cnt +1), the next sample written to bank 0 index 0.
- rst asserted after 20 samples with a frame inflight → all outputs at reset values next cycle. A subsequent 16-sample frame launches from bank 0.
- Macro undefined, overflow run from the fft_ready=0 scenario → ovf=0, drop_cnt=0, same fft_start sequence.
